// File: rtl/vga_timing_detector.sv
// vga_timing_detector: measures incoming hs/vs timing, locks to the expected mode
// and regenerates active_video_area plus x/y for the captured stream.
module vga_timing_detector #(
    parameter bit HS_POLARITY_POSITIVE = 1'b0,
    parameter bit VS_POLARITY_POSITIVE = 1'b0,
    parameter int H_TOTAL              = 800,
    parameter int H_SYNC               = 96,
    parameter int H_ACT_START          = 144,
    parameter int H_ADDR_DUR           = 640,
    parameter int V_TOTAL              = 525,
    parameter int V_ACT_START          = 35,
    parameter int V_ADDR_DUR           = 480,
    parameter int LOCK_FRAMES          = 2,
    parameter int COUNTER_WIDTH        = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hs,
    input  logic                     vs,
    output logic                     locked,
    output logic                     err,
    output logic                     active_video_area,
    output logic [9:0]               x,
    output logic [9:0]               y,
    output logic [COUNTER_WIDTH-1:0] h_total_meas,
    output logic [COUNTER_WIDTH-1:0] h_sync_meas,
    output logic [COUNTER_WIDTH-1:0] v_total_meas
);
    localparam logic [COUNTER_WIDTH-1:0] CMAX    = '1;
    localparam logic [COUNTER_WIDTH-1:0] H_TOT   = COUNTER_WIDTH'(H_TOTAL);
    localparam logic [COUNTER_WIDTH-1:0] H_SW    = COUNTER_WIDTH'(H_SYNC);
    localparam logic [COUNTER_WIDTH-1:0] V_TOT   = COUNTER_WIDTH'(V_TOTAL);
    localparam logic [COUNTER_WIDTH-1:0] HA0     = COUNTER_WIDTH'(H_ACT_START);
    localparam logic [COUNTER_WIDTH-1:0] HA1     = COUNTER_WIDTH'(H_ACT_START + H_ADDR_DUR);
    localparam logic [COUNTER_WIDTH-1:0] VA0     = COUNTER_WIDTH'(V_ACT_START);
    localparam logic [COUNTER_WIDTH-1:0] VA1     = COUNTER_WIDTH'(V_ACT_START + V_ADDR_DUR);
    localparam logic [COUNTER_WIDTH-1:0] GOOD_GO = COUNTER_WIDTH'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
    state_t state;

    logic hs_m, hs_s, hs_d, vs_m, vs_s, vs_d;
    logic hs_a, hs_le, hs_te, vs_le, fs, h_sat;
    logic pending, line_valid, frame_good, line_bad, frame_ok, in_area;
    logic [COUNTER_WIDTH-1:0] h_ctr, v_ctr, hs_cnt, good_cnt, h_next, v_next, hs_cnt_next;

    assign hs_a        = hs_s == HS_POLARITY_POSITIVE;
    assign hs_le       = hs_a && hs_d != HS_POLARITY_POSITIVE;
    assign hs_te       = !hs_a && hs_d == HS_POLARITY_POSITIVE;
    assign vs_le       = vs_s == VS_POLARITY_POSITIVE && vs_d != VS_POLARITY_POSITIVE;
    assign fs          = hs_le && (pending || vs_le);
    assign h_sat       = h_ctr == CMAX;
    assign h_next      = h_sat ? h_ctr : h_ctr + 1'b1;
    assign v_next      = v_ctr == CMAX ? v_ctr : v_ctr + 1'b1;
    assign hs_cnt_next = hs_cnt == CMAX ? hs_cnt : hs_cnt + 1'b1;
    // The line ending at this hs edge is judged on its length and on the sync width captured during it.
    assign line_bad    = hs_le && line_valid && !(h_next == H_TOT && h_sync_meas == H_SW);
    assign frame_ok    = v_next == V_TOT && frame_good && !line_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {hs_m, hs_s, hs_d, vs_m, vs_s, vs_d} <= '0;
            h_ctr        <= '0;
            v_ctr        <= '0;
            hs_cnt       <= '0;
            pending      <= 1'b0;
            line_valid   <= 1'b0;
            frame_good   <= 1'b0;
            h_total_meas <= '0;
            h_sync_meas  <= '0;
            v_total_meas <= '0;
        end else begin
            {hs_m, hs_s, hs_d} <= {hs, hs_m, hs_s};
            {vs_m, vs_s, vs_d} <= {vs, vs_m, vs_s};
            h_ctr  <= hs_le ? '0 : h_next;
            hs_cnt <= hs_a ? hs_cnt_next : '0;
            if (hs_te)
                h_sync_meas <= hs_cnt;
            if (hs_le) begin
                h_total_meas <= h_next;
                line_valid   <= 1'b1;
                v_ctr        <= fs ? '0 : v_next;
            end
            if (fs)
                v_total_meas <= v_next;
            pending    <= fs ? 1'b0 : pending || vs_le;
            frame_good <= fs || (frame_good && !line_bad);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= SEARCH;
            good_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                SEARCH: if (fs) begin
                    state    <= VERIFY;
                    good_cnt <= '0;
                end
                VERIFY: if (h_sat) begin
                    state <= SEARCH;
                end else if (fs) begin
                    good_cnt <= frame_ok ? good_cnt + 1'b1 : '0;
                    if (frame_ok && good_cnt + 1'b1 == GOOD_GO)
                        state <= LOCKED;
                end
                LOCKED: if (h_sat || line_bad || (fs && !frame_ok)) begin
                    state <= SEARCH;
                    err   <= 1'b1;
                end
                default: state <= SEARCH;
            endcase
        end
    end

    assign locked            = state == LOCKED;
    assign in_area           = h_ctr >= HA0 && h_ctr < HA1 && v_ctr >= VA0 && v_ctr < VA1;
    assign active_video_area = locked && in_area;
    assign x                 = active_video_area ? 10'(h_ctr - HA0) : '0;
    assign y                 = active_video_area ? 10'(v_ctr - VA0) : '0;
endmodule

// File: tb/tb_vga_timing_detector.sv
// tb_vga_timing_detector: directed checks of measurement, locking, unlock/err and x/y
// regeneration on a scaled-down timing so several frames fit in a short run.
module tb_vga_timing_detector;
    localparam int HT = 40, HSW = 6, HAS = 10, HAD = 24;
    localparam int VT = 20, VSW = 2, VAS = 3, VAD = 14, CW = 11;

    logic clk = 1'b0, rst = 1'b0, hs = 1'b1, vs = 1'b1;
    logic locked, err, act, p_locked, p_err, p_act, n_locked, n_err, n_act;
    logic [9:0] x, y, p_x, p_y, n_x, n_y;
    logic [CW-1:0] htm, hsm, vtm, p_htm, p_hsm, p_vtm, n_htm, n_hsm, n_vtm;

    int checks = 0, failures = 0;
    int sh = 0, sv = 0, hlen = HT;
    bit src_en = 1'b0, hs_run = 1'b1, n_seen = 1'b0;
    bit qa[3];
    int qx[3], qy[3];
    int pix_bad = 0, pix_n = 0, err_n = 0, max_x = 0, max_y = 0, e0 = 0;

    always #5 clk = ~clk;

    vga_timing_detector #(.H_TOTAL(HT), .H_SYNC(HSW), .H_ACT_START(HAS), .H_ADDR_DUR(HAD),
        .V_TOTAL(VT), .V_ACT_START(VAS), .V_ADDR_DUR(VAD), .LOCK_FRAMES(2), .COUNTER_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs), .locked(locked), .err(err),
        .active_video_area(act), .x(x), .y(y),
        .h_total_meas(htm), .h_sync_meas(hsm), .v_total_meas(vtm));

    vga_timing_detector #(.HS_POLARITY_POSITIVE(1'b1), .VS_POLARITY_POSITIVE(1'b1),
        .H_TOTAL(HT), .H_SYNC(HSW), .H_ACT_START(HAS), .H_ADDR_DUR(HAD),
        .V_TOTAL(VT), .V_ACT_START(VAS), .V_ADDR_DUR(VAD), .LOCK_FRAMES(2), .COUNTER_WIDTH(CW)) dutp (
        .clk(clk), .rst(rst), .hs(~hs), .vs(~vs), .locked(p_locked), .err(p_err),
        .active_video_area(p_act), .x(p_x), .y(p_y),
        .h_total_meas(p_htm), .h_sync_meas(p_hsm), .v_total_meas(p_vtm));

    vga_timing_detector #(.HS_POLARITY_POSITIVE(1'b1), .VS_POLARITY_POSITIVE(1'b1),
        .H_TOTAL(HT), .H_SYNC(HSW), .H_ACT_START(HAS), .H_ADDR_DUR(HAD),
        .V_TOTAL(VT), .V_ACT_START(VAS), .V_ADDR_DUR(VAD), .LOCK_FRAMES(2), .COUNTER_WIDTH(CW)) dutn (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs), .locked(n_locked), .err(n_err),
        .active_video_area(n_act), .x(n_x), .y(n_y),
        .h_total_meas(n_htm), .h_sync_meas(n_hsm), .v_total_meas(n_vtm));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One pixel clock: compare against the source delayed by three clocks, then drive the next sync value.
    task automatic tick();
        logic ea;
        logic [9:0] ex, ey;
        @(negedge clk);
        ea = locked && qa[2];
        ex = ea ? 10'(qx[2]) : 10'd0;
        ey = ea ? 10'(qy[2]) : 10'd0;
        if (hs_run && {act, x, y} !== {ea, ex, ey})
            pix_bad++;
        if (act) begin
            pix_n++;
            if (int'(x) > max_x) max_x = int'(x);
            if (int'(y) > max_y) max_y = int'(y);
        end
        if (err) err_n++;
        if (n_locked) n_seen = 1'b1;
        qa[2] = qa[1]; qa[1] = qa[0];
        qx[2] = qx[1]; qx[1] = qx[0];
        qy[2] = qy[1]; qy[1] = qy[0];
        hs = !(src_en && hs_run && sh < HSW);
        vs = !(src_en && sv < VSW);
        qa[0] = src_en && sh >= HAS && sh < HAS + HAD && sv >= VAS && sv < VAS + VAD;
        qx[0] = sh - HAS;
        qy[0] = sv - VAS;
        if (src_en) begin
            if (sh == hlen - 1) begin
                sh = 0;
                hlen = HT;
                sv = (sv == VT - 1) ? 0 : sv + 1;
            end else begin
                sh++;
            end
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    initial begin
        src_en = 1'b1;
        ticks(100);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_act", act, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_htm", htm, 0);
        check("rst_hsm", hsm, 0);
        check("rst_vtm", vtm, 0);
        src_en = 1'b0;
        ticks(4);
        sh = 0; sv = 0; hlen = HT;
        rst = 1'b1;
        src_en = 1'b1;

        ticks(2 * VT * HT + 3);
        check("lock_pre", locked, 0);
        check("p_lock_pre", p_locked, 0);
        tick();
        check("lock_rise", locked, 1);
        check("p_lock_rise", p_locked, 1);
        check("htm", htm, HT);
        check("hsm", hsm, HSW);
        check("vtm", vtm, VT);
        check("p_htm", p_htm, HT);
        check("p_hsm", p_hsm, HSW);
        check("p_vtm", p_vtm, VT);
        check("n_hsm", n_hsm, HT - HSW);

        pix_n = 0; max_x = 0; max_y = 0;
        ticks(VT * HT);
        check("pix_count", pix_n, HAD * VAD);
        check("max_x", max_x, HAD - 1);
        check("max_y", max_y, VAD - 1);
        check("pix_bad_a", pix_bad, 0);
        ticks(VT * HT - 4);
        check("still_locked", locked, 1);

        e0 = err_n;
        hlen = HT + 1;
        ticks(45);
        check("err_rise", err, 1);
        check("htm_long", htm, HT + 1);
        tick();
        check("err_fall", err, 0);
        check("unlock", locked, 0);
        ticks(755 + 2 * VT * HT + 3);
        check("relock_pre", locked, 0);
        tick();
        check("relock", locked, 1);
        check("err_once", err_n - e0, 1);

        ticks(416);
        check("mid_act", act, 1);
        check("mid_x", x, 6);
        check("mid_y", y, 7);
        #2 rst = 1'b0;
        #1;
        check("arst_locked", locked, 0);
        check("arst_act", act, 0);
        check("arst_x", x, 0);
        check("arst_y", y, 0);
        check("arst_htm", htm, 0);
        ticks(5);
        rst = 1'b1;
        ticks(375 + 2 * VT * HT + 3);
        check("rlock_pre", locked, 0);
        tick();
        check("rlock", locked, 1);
        check("pix_bad_b", pix_bad, 0);

        e0 = err_n;
        hs_run = 1'b0;
        ticks(1900);
        check("stop_locked", locked, 1);
        check("stop_no_err", err_n - e0, 0);
        ticks(300);
        check("sat_unlock", locked, 0);
        ticks(500);
        check("sat_err_once", err_n - e0, 1);
        check("n_never_locked", n_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_timing_detector.md
Name: vga_timing_detector

Overview:
- Receive-side counterpart of the VGA display timing controller.
- Takes hs/vs from a VGA source and measures line length, hsync width and frame length, then checks them against the expected 640x480 timings.
- Locks after consecutive good frames and regenerates active_video_area and the x/y pixel position.
- Used as a loopback checker on the display timing output and as the sync front-end for capture paths.

Parameters:
HS_POLARITY_POSITIVE, 0, hs asserted level during sync (0 = active-low)
VS_POLARITY_POSITIVE, 0, vs asserted level during sync
H_TOTAL, 800, expected clocks per line
H_SYNC, 96, expected hsync width in clocks
H_ACT_START, 144, h count of first active pixel (sync+back porch+left border)
H_ADDR_DUR, 640, active pixels per line
V_TOTAL, 525, expected lines per frame
V_ACT_START, 35, v count of first active line
V_ADDR_DUR, 480, active lines per frame
LOCK_FRAMES, 2, consecutive good frames required to lock
COUNTER_WIDTH, 11, width of h/v counters and measurement outputs

Ports:
clk  in  1  pixel clock
rst  in  1  reset, asynchronous, active-low
hs  in  1  horizontal sync from source
vs  in  1  vertical sync from source
locked  out  1  timing matches parameters; x/y/active valid
err  out  1  one-cycle pulse on loss of lock
active_video_area  out  1  current pixel in active area (only while locked)
x  out  10  pixel column, 0..H_ADDR_DUR-1, 0 when inactive
y  out  10  pixel row, 0..V_ADDR_DUR-1, 0 when inactive
h_total_meas  out  COUNTER_WIDTH  last measured line length in clocks
h_sync_meas  out  COUNTER_WIDTH  last measured hsync width in clocks
v_total_meas  out  COUNTER_WIDTH  last measured frame length in lines

Behaviour:
- Reset (rst=0, async) clears all flops. Outputs go to 0, state goes to SEARCH.
- hs and vs each pass through a 2-flop synchroniser, then one edge-detect flop.
- Asserted means the synchronised level equals the polarity parameter. Leading edge means deasserted→asserted.
- h_ctr:
  - Loads 0 on the clock after an hs leading edge is detected; otherwise increments.
  - Saturates at 2^COUNTER_WIDTH-1.
  - Net effect: h_ctr equals the source counter delayed by exactly 3 clocks.
- On an hs leading edge: h_total_meas <= h_ctr+1.
- hsync width: count clocks while hs is asserted; on the trailing edge capture the count into h_sync_meas.
- vs leading edge sets a pending flag. The first hs leading edge with pending set, or with a vs leading edge in the same cycle, is the frame start:
  - v_total_meas <= v_ctr+1
  - v_ctr <= 0
  - pending cleared
- Other hs leading edges: v_ctr increments, saturating.
- line_ok: h_total_meas==H_TOTAL and h_sync_meas==H_SYNC, evaluated at each hs leading edge after the first line.
- frame_ok: v_total_meas==V_TOTAL and every line since the previous frame start was line_ok.
- FSM:
  - SEARCH: at the first frame start go to VERIFY with good_cnt=0; the partial first frame is discarded.
  - VERIFY: at each frame start, frame_ok increments good_cnt, otherwise good_cnt=0. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: a bad line (at that hs edge), a bad frame, or h_ctr saturation goes to SEARCH; err pulses for 1 cycle and locked drops on the next clock.
  - h_ctr saturation in VERIFY goes to SEARCH with no err pulse.
  - err never pulses outside LOCKED.
- locked = (state==LOCKED).
- active_video_area = locked and H_ACT_START ≤ h_ctr < H_ACT_START+H_ADDR_DUR and V_ACT_START ≤ v_ctr < V_ACT_START+V_ADDR_DUR. It is a combinational decode of registered state.
- x = h_ctr-H_ACT_START and y = v_ctr-V_ACT_START, truncated to 10 bits, when active; 0 otherwise.
- Simultaneous vs and hs leading edges count as a frame start in that cycle.
- A glitchy or mis-polarity sync never produces active_video_area, because active_video_area is gated by locked.

Test Plan:
1. Hold rst=0 with free-running clk and toggling syncs → locked=0, err=0, active_video_area=0, x=y=0, all *_meas=0.
2. Drive hs/vs from the display timing controller at defaults → locked rises at the 3rd frame start after reset release. h_total_meas=800, h_sync_meas=96, v_total_meas=525. active_video_area asserts 3 clocks after the source's, with x sweeping 0..639 and y 0..479.
3. While locked, stretch one line to 801 clocks → at that hs edge err=1 for exactly 1 cycle, locked=0 next cycle, h_total_meas=801. Relock after 3 further clean frame starts.
4. While locked, stop hs (hold deasserted) → h_ctr saturates at 2047, single err pulse, locked=0. No further err pulses while hs stays stopped.
5. Set HS_POLARITY_POSITIVE=VS_POLARITY_POSITIVE=1 with inverted source syncs → locks as in scenario 2. With non-inverted syncs → h_sync_meas=704, locked never asserts.
6. Assert rst mid-frame while locked, with no clock edge → locked, active_video_area, x and y go to 0 immediately. After release, relock at the 3rd frame start.
